// File: rtl/flash_seq_wr_burst.sv
// flash_seq_wr_burst: buffers incoming bytes in a FIFO and programs them into
// an SPI flash as WREN + Page Program bursts, polling RDSR after each burst.
//
// Input handshake: pi_flag is a one-cycle strobe with pi_data valid in that
// cycle. There is no ready/backpressure. A byte that arrives while the FIFO is
// full is dropped, and the sticky ovf flag records the loss.
module flash_seq_wr_burst #(
  parameter logic [23:0] START_ADDR = 24'h000000,
  parameter int          SCK_DIV    = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter int          PAGE_SIZE  = 256,
  parameter int          CS_GAP     = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        pi_flag,
  input  logic [7:0]  pi_data,
  input  logic        miso,
  output logic        sck,
  output logic        cs_n,
  output logic        mosi,
  output logic        busy,
  output logic        ovf,
  output logic [23:0] wr_addr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_GAP - 1);
  localparam logic [23:0]   PAGE_MASK = 24'(PAGE_SIZE - 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    CMD_WREN  = 8'h06;
  localparam logic [7:0]    CMD_PP    = 8'h02;
  localparam logic [7:0]    CMD_RDSR  = 8'h05;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WREN = 3'd1,
    S_GAP  = 3'd2,
    S_PP   = 3'd3,
    S_RDSR = 3'd4
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          ovf_q;
  logic          push, pop;

  // Sequencer state and registered SPI/status outputs
  state_t        state_q, nxt_q;
  logic          sck_q, cs_n_q, mosi_q, busy_q;
  logic [23:0]   wr_addr_q;
  logic [7:0]    sh_q, rx_q;
  logic [DW-1:0] div_cnt_q;
  logic          phase_q;
  logic [2:0]    bit_cnt_q;
  logic [2:0]    byte_idx_q;
  logic [GW-1:0] gap_cnt_q;

  logic          in_frame, bit_end, byte_end, page_end, more_bytes;
  logic [23:0]   addr_inc;
  logic [7:0]    next_byte, start_cmd;

  // Occupancy is the registered count, so a same-cycle pop never makes room.
  assign push = pi_flag && (count_q < FIFO_FULL);

  assign in_frame = (state_q == S_WREN) || (state_q == S_PP) || (state_q == S_RDSR);
  assign bit_end  = in_frame && phase_q && (div_cnt_q == DIV_LAST);
  assign byte_end = bit_end && (bit_cnt_q == 3'd7);
  assign addr_inc = wr_addr_q + 24'd1;
  assign page_end = (addr_inc & PAGE_MASK) == 24'd0;

  // Byte index 0..2 is the address header, 3 is the first data byte, 4 marks
  // data bytes where the page/FIFO continue rule applies.
  always_comb begin
    more_bytes = 1'b0;
    next_byte  = 8'h00;
    case (state_q)
      S_PP: begin
        case (byte_idx_q)
          3'd0: begin more_bytes = 1'b1; next_byte = wr_addr_q[23:16]; end
          3'd1: begin more_bytes = 1'b1; next_byte = wr_addr_q[15:8];  end
          3'd2: begin more_bytes = 1'b1; next_byte = wr_addr_q[7:0];   end
          3'd3: begin more_bytes = 1'b1; next_byte = mem_q[rptr_q];    end
          default: begin
            more_bytes = (count_q != '0) && !page_end;
            next_byte  = mem_q[rptr_q];
          end
        endcase
      end
      S_RDSR: begin
        more_bytes = (byte_idx_q == 3'd0);
        next_byte  = 8'h00;
      end
      default: begin
        more_bytes = 1'b0;
        next_byte  = 8'h00;
      end
    endcase
  end

  // A data byte leaves the FIFO on the edge that drives its first bit.
  assign pop = byte_end && (state_q == S_PP) && more_bytes && (byte_idx_q >= 3'd3);

  assign start_cmd = (state_q == S_IDLE) ? CMD_WREN :
                     (nxt_q == S_PP)     ? CMD_PP   : CMD_RDSR;

  // FIFO data array; contents need no reset because pointers guard reads.
  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wptr_q] <= pi_data;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (pi_flag && !push) ovf_q <= 1'b1;
    end
  end

  // Burst sequencer: frame bit engine, inter-frame gap and address tracking.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      nxt_q      <= S_IDLE;
      sck_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= START_ADDR;
      sh_q       <= 8'h00;
      rx_q       <= 8'h00;
      div_cnt_q  <= '0;
      phase_q    <= 1'b0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      gap_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != '0) begin
            state_q <= S_WREN;
            busy_q  <= 1'b1;
            cs_n_q  <= 1'b0;
            mosi_q  <= start_cmd[7];
            sh_q    <= {start_cmd[6:0], 1'b0};
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gap_cnt_q <= '0;
            if (nxt_q == S_IDLE) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= nxt_q;
              cs_n_q  <= 1'b0;
              mosi_q  <= start_cmd[7];
              sh_q    <= {start_cmd[6:0], 1'b0};
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + GW'(1);
          end
        end
        S_WREN, S_PP, S_RDSR: begin
          if (div_cnt_q != DIV_LAST) begin
            div_cnt_q <= div_cnt_q + DW'(1);
          end else begin
            div_cnt_q <= '0;
            phase_q   <= ~phase_q;
            if (!phase_q) begin
              sck_q <= 1'b1;
              rx_q  <= {rx_q[6:0], miso};
            end else begin
              sck_q <= 1'b0;
              if (bit_cnt_q != 3'd7) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                mosi_q    <= sh_q[7];
                sh_q      <= {sh_q[6:0], 1'b0};
              end else begin
                bit_cnt_q <= 3'd0;
                if (state_q == S_PP && byte_idx_q == 3'd4) wr_addr_q <= addr_inc;
                if (more_bytes) begin
                  if (byte_idx_q != 3'd4) byte_idx_q <= byte_idx_q + 3'd1;
                  mosi_q <= next_byte[7];
                  sh_q   <= {next_byte[6:0], 1'b0};
                end else begin
                  byte_idx_q <= 3'd0;
                  cs_n_q     <= 1'b1;
                  mosi_q     <= 1'b0;
                  state_q    <= S_GAP;
                  case (state_q)
                    S_WREN:  nxt_q <= S_PP;
                    S_PP:    nxt_q <= S_RDSR;
                    default: nxt_q <= rx_q[0] ? S_RDSR : S_IDLE;
                  endcase
                end
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cs_n_q  <= 1'b1;
          sck_q   <= 1'b0;
          mosi_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sck     = sck_q;
  assign cs_n    = cs_n_q;
  assign mosi    = mosi_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign wr_addr = wr_addr_q;

endmodule

// File: tb/tb_flash_seq_wr_burst.sv
// Directed bench for flash_seq_wr_burst. Three instances cover the default
// configuration (A), a page-boundary start with a 4-entry FIFO (B) and an
// address-space wrap start (C). A per-instance SPI monitor records frames.
module tb_flash_seq_wr_burst;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst_n;
  logic [2:0]  pi_flag;
  logic [7:0]  pi_data [3];
  logic [2:0]  miso;
  wire  [2:0]  sck, cs_n, mosi, busy, ovf;
  wire  [23:0] wr_addr_w [3];

  int n_chk;
  int n_pass;

  flash_seq_wr_burst u_a (
    .sys_clk(clk), .sys_rst_n(rst_n[0]), .pi_flag(pi_flag[0]), .pi_data(pi_data[0]),
    .miso(miso[0]), .sck(sck[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .busy(busy[0]),
    .ovf(ovf[0]), .wr_addr(wr_addr_w[0])
  );

  flash_seq_wr_burst #(.START_ADDR(24'h0000FE), .FIFO_DEPTH(4)) u_b (
    .sys_clk(clk), .sys_rst_n(rst_n[1]), .pi_flag(pi_flag[1]), .pi_data(pi_data[1]),
    .miso(miso[1]), .sck(sck[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .busy(busy[1]),
    .ovf(ovf[1]), .wr_addr(wr_addr_w[1])
  );

  flash_seq_wr_burst #(.START_ADDR(24'hFFFFFF)) u_c (
    .sys_clk(clk), .sys_rst_n(rst_n[2]), .pi_flag(pi_flag[2]), .pi_data(pi_data[2]),
    .miso(miso[2]), .sck(sck[2]), .cs_n(cs_n[2]), .mosi(mosi[2]), .busy(busy[2]),
    .ovf(ovf[2]), .wr_addr(wr_addr_w[2])
  );

  // ---------------- SPI monitor / flash status model ----------------
  logic [7:0] fb   [3][16][12];
  int         fnb  [3][16];
  int         flen [3][16];
  int         fgap [3][16];
  int         nfr [3];
  int         cur_nb [3];
  int         cur_len [3];
  int         hi_cnt [3];
  int         rdsr_cnt [3];
  int         n_wip [3];
  logic       in_fr [3];
  logic       sck_prev [3];
  logic [7:0] mon_stat;

  // Sample bus mid-cycle, capture mosi on sck rise, and drive miso for RDSR.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cs_n[k] == 1'b0) begin
        if (!in_fr[k]) begin
          in_fr[k]   = 1'b1;
          cur_nb[k]  = 0;
          cur_len[k] = 0;
          if (nfr[k] < 16) fgap[k][nfr[k]] = hi_cnt[k];
        end
        cur_len[k]++;
        if (sck[k] && !sck_prev[k]) begin
          if (nfr[k] < 16 && cur_nb[k] < 96)
            fb[k][nfr[k]][cur_nb[k] / 8][7 - (cur_nb[k] % 8)] = mosi[k];
          cur_nb[k]++;
        end
      end else begin
        if (in_fr[k]) begin
          if (nfr[k] < 16) begin
            fnb[k][nfr[k]]  = cur_nb[k];
            flen[k][nfr[k]] = cur_len[k];
            if (cur_nb[k] == 16 && fb[k][nfr[k]][0] == 8'h05) rdsr_cnt[k]++;
          end
          nfr[k]++;
          in_fr[k]  = 1'b0;
          hi_cnt[k] = 0;
        end
        hi_cnt[k]++;
      end
      sck_prev[k] = sck[k];
      miso[k] = 1'b0;
      if (in_fr[k] && cur_nb[k] >= 8 && cur_nb[k] < 16 && nfr[k] < 16) begin
        if (fb[k][nfr[k]][0] == 8'h05) begin
          mon_stat = (rdsr_cnt[k] < n_wip[k]) ? 8'h01 : 8'h00;
          miso[k] = mon_stat[15 - cur_nb[k]];
        end
      end
    end
  end

  function automatic logic [95:0] fbytes(input int k, input int f, input int n);
    logic [95:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[87:0], fb[k][f][i]};
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the edge that sampled it.
  task automatic push(input int k, input logic [7:0] d);
    pi_flag[k] = 1'b1;
    pi_data[k] = d;
    @(posedge clk); #1;
    pi_flag[k] = 1'b0;
  endtask

  task automatic wait_quiet(input int k, input string name);
    int low;
    bit ok;
    low = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (busy[k] === 1'b0) low++; else low = 0;
      if (low >= 8) begin ok = 1'b1; break; end
    end
    n_chk++; if (!ok) $display("FAIL %s_idle: busy never settled low within 20000 cycles", name); else n_pass++;
  endtask

  task automatic wait_frames(input int k, input int target, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if (nfr[k] >= target) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (!ok) $display("FAIL %s_frames: got %0d frames, required %0d", name, nfr[k], target); else n_pass++;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n   = 3'b000;
    pi_flag = 3'b000;
    for (int k = 0; k < 3; k++) begin
      pi_data[k] = 8'h00; nfr[k] = 0; cur_nb[k] = 0; cur_len[k] = 0; hi_cnt[k] = 0;
      rdsr_cnt[k] = 0; n_wip[k] = 0; in_fr[k] = 1'b0; sck_prev[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (sck[0] !== 1'b0) $display("FAIL reset_sck: got %b required 0", sck[0]); else n_pass++;
    n_chk++; if (cs_n[0] !== 1'b1) $display("FAIL reset_cs_n: got %b required 1", cs_n[0]); else n_pass++;
    n_chk++; if (mosi[0] !== 1'b0) $display("FAIL reset_mosi: got %b required 0", mosi[0]); else n_pass++;
    n_chk++; if (busy[0] !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy[0]); else n_pass++;
    n_chk++; if (ovf[0] !== 1'b0) $display("FAIL reset_ovf: got %b required 0", ovf[0]); else n_pass++;
    n_chk++; if (wr_addr_w[0] !== 24'h000000) $display("FAIL reset_addr_a: got %h required 000000", wr_addr_w[0]); else n_pass++;
    n_chk++; if (wr_addr_w[1] !== 24'h0000FE) $display("FAIL reset_addr_b: got %h required 0000fe", wr_addr_w[1]); else n_pass++;
    n_chk++; if (wr_addr_w[2] !== 24'hFFFFFF) $display("FAIL reset_addr_c: got %h required ffffff", wr_addr_w[2]); else n_pass++;
  endtask

  task automatic test_single_byte();
    int b;
    b = nfr[0];
    push(0, 8'hA5);
    n_chk++; if (cs_n[0] !== 1'b1) $display("FAIL single_latency_pre: cs_n got %b required 1", cs_n[0]); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (cs_n[0] !== 1'b0) $display("FAIL single_cs_fall: cs_n got %b required 0", cs_n[0]); else n_pass++;
    n_chk++; if (busy[0] !== 1'b1) $display("FAIL single_busy_rise: got %b required 1", busy[0]); else n_pass++;
    wait_quiet(0, "single");
    n_chk++; if (nfr[0] !== b + 3) $display("FAIL single_nframes: got %0d required %0d", nfr[0] - b, 3); else n_pass++;
    n_chk++; if (fnb[0][b] !== 8 || fbytes(0, b, 1) !== 96'h06) $display("FAIL single_wren: bits %0d byte %h required 8 bits 06", fnb[0][b], fbytes(0, b, 1)); else n_pass++;
    n_chk++; if (flen[0][b] !== 32) $display("FAIL single_wren_len: got %0d required 32", flen[0][b]); else n_pass++;
    n_chk++; if (fnb[0][b+1] !== 40 || fbytes(0, b+1, 5) !== 96'h02000000A5) $display("FAIL single_pp: bits %0d bytes %h required 40 bits 02000000a5", fnb[0][b+1], fbytes(0, b+1, 5)); else n_pass++;
    n_chk++; if (flen[0][b+1] !== 160) $display("FAIL single_pp_len: got %0d required 160", flen[0][b+1]); else n_pass++;
    n_chk++; if (fgap[0][b+1] !== 4) $display("FAIL single_gap1: got %0d required 4", fgap[0][b+1]); else n_pass++;
    n_chk++; if (fnb[0][b+2] !== 16 || fbytes(0, b+2, 2) !== 96'h0500) $display("FAIL single_rdsr: bits %0d bytes %h required 16 bits 0500", fnb[0][b+2], fbytes(0, b+2, 2)); else n_pass++;
    n_chk++; if (flen[0][b+2] !== 64) $display("FAIL single_rdsr_len: got %0d required 64", flen[0][b+2]); else n_pass++;
    n_chk++; if (fgap[0][b+2] !== 4) $display("FAIL single_gap2: got %0d required 4", fgap[0][b+2]); else n_pass++;
    n_chk++; if (wr_addr_w[0] !== 24'h000001) $display("FAIL single_addr: got %h required 000001", wr_addr_w[0]); else n_pass++;
    n_chk++; if (cs_n[0] !== 1'b1 || sck[0] !== 1'b0) $display("FAIL single_idle_bus: cs_n %b sck %b required 1 0", cs_n[0], sck[0]); else n_pass++;
  endtask

  task automatic test_rdsr_polls();
    int b;
    b = nfr[0];
    rdsr_cnt[0] = 0;
    n_wip[0] = 3;
    push(0, 8'h3C);
    wait_quiet(0, "polls");
    n_wip[0] = 0;
    n_chk++; if (nfr[0] !== b + 6) $display("FAIL polls_nframes: got %0d required 6", nfr[0] - b); else n_pass++;
    n_chk++; if (fbytes(0, b+1, 5) !== 96'h020000013C) $display("FAIL polls_pp: got %h required 020000013c", fbytes(0, b+1, 5)); else n_pass++;
    for (int i = 2; i < 6; i++) begin
      n_chk++; if (fnb[0][b+i] !== 16 || fbytes(0, b+i, 2) !== 96'h0500) $display("FAIL polls_rdsr%0d: bits %0d bytes %h required 16 bits 0500", i - 2, fnb[0][b+i], fbytes(0, b+i, 2)); else n_pass++;
      n_chk++; if (fgap[0][b+i] !== 4) $display("FAIL polls_gap%0d: got %0d required 4", i - 2, fgap[0][b+i]); else n_pass++;
    end
    n_chk++; if (rdsr_cnt[0] !== 4) $display("FAIL polls_count: got %0d required 4", rdsr_cnt[0]); else n_pass++;
    n_chk++; if (wr_addr_w[0] !== 24'h000002) $display("FAIL polls_addr: got %h required 000002", wr_addr_w[0]); else n_pass++;
  endtask

  task automatic test_page_cross();
    int b;
    b = nfr[1];
    push(1, 8'h11);
    push(1, 8'h22);
    push(1, 8'h33);
    push(1, 8'h44);
    wait_quiet(1, "page");
    n_chk++; if (nfr[1] !== b + 6) $display("FAIL page_nframes: got %0d required 6", nfr[1] - b); else n_pass++;
    n_chk++; if (fnb[1][b+1] !== 48 || fbytes(1, b+1, 6) !== 96'h020000FE1122) $display("FAIL page_pp1: bits %0d bytes %h required 48 bits 020000fe1122", fnb[1][b+1], fbytes(1, b+1, 6)); else n_pass++;
    n_chk++; if (flen[1][b+1] !== 192) $display("FAIL page_pp1_len: got %0d required 192", flen[1][b+1]); else n_pass++;
    n_chk++; if (fbytes(1, b+3, 1) !== 96'h06) $display("FAIL page_wren2: got %h required 06", fbytes(1, b+3, 1)); else n_pass++;
    n_chk++; if (fgap[1][b+3] !== 5) $display("FAIL page_idle_gap: got %0d required 5", fgap[1][b+3]); else n_pass++;
    n_chk++; if (fnb[1][b+4] !== 48 || fbytes(1, b+4, 6) !== 96'h020001003344) $display("FAIL page_pp2: bits %0d bytes %h required 48 bits 020001003344", fnb[1][b+4], fbytes(1, b+4, 6)); else n_pass++;
    n_chk++; if (wr_addr_w[1] !== 24'h000102) $display("FAIL page_addr: got %h required 000102", wr_addr_w[1]); else n_pass++;
    n_chk++; if (ovf[1] !== 1'b0) $display("FAIL page_ovf: got %b required 0", ovf[1]); else n_pass++;
  endtask

  task automatic test_overflow();
    int b;
    b = nfr[1];
    push(1, 8'h50);
    wait_frames(1, b + 2, "ovf");
    push(1, 8'h60);
    push(1, 8'h61);
    push(1, 8'h62);
    push(1, 8'h63);
    n_chk++; if (ovf[1] !== 1'b0) $display("FAIL ovf_at_full: got %b required 0", ovf[1]); else n_pass++;
    push(1, 8'h64);
    n_chk++; if (ovf[1] !== 1'b1) $display("FAIL ovf_set: got %b required 1", ovf[1]); else n_pass++;
    push(1, 8'h65);
    wait_quiet(1, "ovf");
    n_chk++; if (nfr[1] !== b + 6) $display("FAIL ovf_nframes: got %0d required 6", nfr[1] - b); else n_pass++;
    n_chk++; if (fbytes(1, b+1, 5) !== 96'h0200010250) $display("FAIL ovf_pp1: got %h required 0200010250", fbytes(1, b+1, 5)); else n_pass++;
    n_chk++; if (fnb[1][b+4] !== 64 || fbytes(1, b+4, 8) !== 96'h0200010360616263) $display("FAIL ovf_pp2: bits %0d bytes %h required 64 bits 0200010360616263", fnb[1][b+4], fbytes(1, b+4, 8)); else n_pass++;
    n_chk++; if (flen[1][b+4] !== 256) $display("FAIL ovf_pp2_len: got %0d required 256", flen[1][b+4]); else n_pass++;
    n_chk++; if (wr_addr_w[1] !== 24'h000107) $display("FAIL ovf_addr: got %h required 000107", wr_addr_w[1]); else n_pass++;
    n_chk++; if (ovf[1] !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", ovf[1]); else n_pass++;
  endtask

  task automatic test_wrap();
    int b;
    b = nfr[2];
    push(2, 8'h77);
    push(2, 8'h88);
    wait_frames(2, b + 2, "wrap");
    n_chk++; if (wr_addr_w[2] !== 24'h000000) $display("FAIL wrap_addr_mid: got %h required 000000", wr_addr_w[2]); else n_pass++;
    wait_quiet(2, "wrap");
    n_chk++; if (nfr[2] !== b + 6) $display("FAIL wrap_nframes: got %0d required 6", nfr[2] - b); else n_pass++;
    n_chk++; if (fnb[2][b+1] !== 40 || fbytes(2, b+1, 5) !== 96'h02FFFFFF77) $display("FAIL wrap_pp1: bits %0d bytes %h required 40 bits 02ffffff77", fnb[2][b+1], fbytes(2, b+1, 5)); else n_pass++;
    n_chk++; if (fnb[2][b+4] !== 40 || fbytes(2, b+4, 5) !== 96'h0200000088) $display("FAIL wrap_pp2: bits %0d bytes %h required 40 bits 0200000088", fnb[2][b+4], fbytes(2, b+4, 5)); else n_pass++;
    n_chk++; if (wr_addr_w[2] !== 24'h000001) $display("FAIL wrap_addr_end: got %h required 000001", wr_addr_w[2]); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int b;
    int hits;
    bit ok;
    b = nfr[0];
    ok = 1'b0;
    push(0, 8'h99);
    for (int i = 0; i < 5000; i++) begin
      if (nfr[0] == b + 1 && in_fr[0] && cur_nb[0] >= 12) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_chk++; if (!ok) $display("FAIL rst_reach_addr: address byte never observed, frames %0d", nfr[0] - b); else n_pass++;
    rst_n[0] = 1'b0;
    #1;
    n_chk++; if (cs_n[0] !== 1'b1) $display("FAIL rst_cs_n: got %b required 1", cs_n[0]); else n_pass++;
    n_chk++; if (sck[0] !== 1'b0) $display("FAIL rst_sck: got %b required 0", sck[0]); else n_pass++;
    n_chk++; if (mosi[0] !== 1'b0) $display("FAIL rst_mosi: got %b required 0", mosi[0]); else n_pass++;
    n_chk++; if (busy[0] !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy[0]); else n_pass++;
    n_chk++; if (wr_addr_w[0] !== 24'h000000) $display("FAIL rst_addr: got %h required 000000", wr_addr_w[0]); else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst_n[0] = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy[0] !== 1'b0 || cs_n[0] !== 1'b1) hits++;
    end
    n_chk++; if (hits !== 0) $display("FAIL rst_fifo_flushed: busy cycles %0d required 0", hits); else n_pass++;
    b = nfr[0];
    push(0, 8'hC3);
    wait_quiet(0, "rst");
    n_chk++; if (fbytes(0, b+1, 5) !== 96'h02000000C3) $display("FAIL rst_next_pp: got %h required 02000000c3", fbytes(0, b+1, 5)); else n_pass++;
    n_chk++; if (wr_addr_w[0] !== 24'h000001) $display("FAIL rst_next_addr: got %h required 000001", wr_addr_w[0]); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    test_reset();
    test_single_byte();
    test_rdsr_polls();
    test_page_cross();
    test_overflow();
    test_wrap();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/flash_seq_wr_burst.md
# flash_seq_wr_burst

Parametrised successor of the UART-fed SPI-flash sequential writer. Bytes arriving on a `pi_flag`/`pi_data` strobe are buffered in an internal FIFO and programmed into the flash at consecutive addresses. Each program is a burst: WREN, then one Page Program (0x02) carrying as many queued bytes as fit in the current page. After every burst the block polls the flash status register (RDSR) until the write completes. It sits between `uart_rx` and the SPI flash pins.

## Interface
- `START_ADDR`, 24'h000000: first flash byte address after reset.
- `SCK_DIV`, 2: sck half-period in sys_clk cycles (≥1).
- `FIFO_DEPTH`, 16: input FIFO entries (power of 2, ≥2).
- `PAGE_SIZE`, 256: flash page size in bytes (power of 2, ≤256).
- `CS_GAP`, 4: minimum cs_n high time between frames, in sys_clk cycles (≥1).

Ports:
- `sys_clk`, in, 1: system clock; all logic is on its rising edge.
- `sys_rst_n`, in, 1: asynchronous active-low reset.
- `pi_flag`, in, 1: one-cycle strobe; `pi_data` is valid.
- `pi_data`, in, 8: byte to program.
- `miso`, in, 1: flash serial output; used only during RDSR.
- `sck`, out, 1: SPI clock, mode 0 (idles low).
- `cs_n`, out, 1: flash chip select, active low.
- `mosi`, out, 1: SPI data out, MSB first.
- `busy`, out, 1: high whenever the state is not IDLE.
- `ovf`, out, 1: sticky; set when a byte is dropped because the FIFO is full.
- `wr_addr`, out, 24: address the next byte will be written to.

## Operation
- Reset values: sck=0, cs_n=1, mosi=0, busy=0, ovf=0, wr_addr=START_ADDR, FIFO empty, state IDLE.
- FIFO push:
  - On `pi_flag`, push if occupancy (registered, before any same-cycle pop) < FIFO_DEPTH.
  - Otherwise drop the byte and set ovf.
  - A push and a pop in the same cycle are both honoured.
- State sequence: IDLE → WREN → GAP → PP → GAP → RDSR → (GAP → RDSR)* → GAP → IDLE.
- IDLE: leave when the FIFO is non-empty.
- WREN: one 8-bit frame, 0x06.
- PP frame:
  - 0x02, then wr_addr[23:16], [15:8], [7:0], then data bytes.
  - Each data byte is popped from the FIFO in the cycle its first bit is driven.
  - After each data byte, wr_addr increments; it wraps from 24'hFFFFFF to 0.
  - After each data byte's last bit: continue with another byte only if the FIFO is non-empty AND the incremented wr_addr mod PAGE_SIZE ≠ 0. Otherwise end the frame.
  - A burst therefore carries 1 to PAGE_SIZE bytes and never crosses a page.
- RDSR frame:
  - 16 bits: 0x05 on mosi, then 8 bits sampled from miso (mosi=0 during this byte).
  - If status bit0 (WIP)=1, go to GAP, then repeat RDSR.
  - If WIP=0, go to GAP, then IDLE.
  - There is no poll limit.
- GAP: cs_n=1, sck=0, mosi=0 for exactly CS_GAP cycles.
- Bytes arriving during a burst are queued for the next burst, unless they are taken within the current PP frame by the continue rule.

## Timing
- Bit period is 2·SCK_DIV cycles:
  - sck low for SCK_DIV cycles, then high for SCK_DIV cycles.
  - mosi changes only on the first cycle of the low phase.
  - miso is sampled on the cycle sck rises.
- Frame start: cs_n falls in the same cycle that the first bit's mosi is driven. The first sck rise follows SCK_DIV cycles later.
- Frame end: cs_n rises, and sck returns low, on the cycle after the last bit's high phase ends. mosi returns to 0 at the same time.
- Frame lengths in sys_clk cycles:
  - WREN: 16·SCK_DIV.
  - PP with N data bytes: (32+8N)·2·SCK_DIV.
  - Each RDSR: 32·SCK_DIV.
- IDLE→WREN: cs_n falls 1 cycle after the first FIFO-non-empty cycle.
- Status outputs: busy goes high in the same cycle cs_n first falls, and falls on the cycle the state returns to IDLE. wr_addr updates on the cycle after each data byte's last bit.
- Reset mid-frame: all outputs take reset values immediately (asynchronous) and the FIFO is flushed. No partial frame is resumed.

## Test plan
- Reset, one byte 0xA5 with SCK_DIV=2 and miso=0:
  - mosi frames are 0x06 | 0x02 00 00 00 A5 | 0x05 + 8 read bits.
  - Then IDLE, wr_addr=1, busy low.
- START_ADDR=24'h0000FE, push 4 bytes back-to-back:
  - First PP is at 0x0000FE with 2 bytes.
  - Second burst is at 0x000100 with 2 bytes.
  - Final wr_addr=0x000102.
- miso returns status 0x01 for 3 polls, then 0x00:
  - 4 RDSR frames occur, each separated by CS_GAP cs_n-high cycles, then IDLE.
- FIFO_DEPTH=4, 6 strobes while busy with a burst:
  - Exactly 4 bytes are queued and later programmed.
  - ovf=1 and stays 1.
- START_ADDR=24'hFFFFFF, push 2 bytes:
  - Burst 1 is at 0xFFFFFF with 1 byte; wr_addr wraps to 0.
  - Burst 2 is at 0x000000.
- Assert sys_rst_n low during the PP address byte:
  - cs_n=1, sck=0, mosi=0, busy=0 immediately; FIFO is empty after release.
  - The next byte is written at START_ADDR.
